// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered RISC-V execute stage.
// It computes the ALU result and flags for one operation and hands them downstream
// through a valid/ready handshake. A two-entry skid buffer (OUT + SKID) sits behind the
// handshake, so in_ready depends only on the stage state and never on out_ready.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   in_valid / in_ready      upstream handshake
//   SrcA, SrcB, ALUControl   operands and 3-bit ALU operation code
//   in_rd                    destination tag, carried through unchanged
//   out_valid / out_ready    downstream handshake
//   Result, Zero, Negative, Carry, Overflow, Illegal, out_rd   registered outputs
//   op_count                 count of completed output handshakes, wraps at 2^32
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  input  logic [TAGW-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Illegal,
  output logic [TAGW-1:0]  out_rd,
  output logic [31:0]      op_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             illegal;
    logic [TAGW-1:0]  rd;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e      r_state;
  state_e      w_state_next;
  entry_t      r_out;
  entry_t      r_skid;
  entry_t      w_new;
  logic [31:0] r_op_count;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_out;
  logic             w_out_from_skid;
  logic             w_load_skid;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic             w_slt;

  // Shared adder: subtraction is A + ~B + 1, so its carry-out means A >= B unsigned.
  assign w_is_sub = (ALUControl == 3'b001);
  assign w_b_op   = w_is_sub ? ~SrcB : SrcB;
  assign w_sum    = {1'b0, SrcA} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_slt    = $signed(SrcA) < $signed(SrcB);

  always_comb begin
    w_new    = '0;
    w_new.rd = in_rd;
    case (ALUControl)
      3'b000: begin
        w_new.result   = w_sum[WIDTH-1:0];
        w_new.carry    = w_sum[WIDTH];
        w_new.overflow = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      3'b001: begin
        w_new.result   = w_sum[WIDTH-1:0];
        w_new.carry    = w_sum[WIDTH];
        w_new.overflow = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      3'b010:  w_new.result = SrcA & SrcB;
      3'b011:  w_new.result = SrcA | SrcB;
      3'b101:  w_new.result = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_new.illegal = 1'b1;
    endcase
    w_new.zero     = (w_new.result == '0);
    w_new.negative = w_new.result[WIDTH-1];
  end

  assign in_ready   = (r_state != StFull);
  assign out_valid  = (r_state != StEmpty);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_next    = r_state;
    w_load_out      = 1'b0;
    w_out_from_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      StEmpty: begin
        if (w_in_fire) begin
          w_load_out   = 1'b1;
          w_state_next = StOne;
        end
      end
      StOne: begin
        if (w_in_fire && w_out_fire) begin
          w_load_out = 1'b1;
        end else if (w_in_fire) begin
          w_load_skid  = 1'b1;
          w_state_next = StFull;
        end else if (w_out_fire) begin
          w_state_next = StEmpty;
        end
      end
      StFull: begin
        if (w_out_fire) begin
          w_load_out      = 1'b1;
          w_out_from_skid = 1'b1;
          w_state_next    = StOne;
        end
      end
      default: w_state_next = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StEmpty;
      r_out      <= '0;
      r_skid     <= '0;
      r_op_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_out) r_out <= w_out_from_skid ? r_skid : w_new;
      if (w_load_skid) r_skid <= w_new;
      if (w_out_fire) r_op_count <= r_op_count + 32'd1;
    end
  end

  assign Result   = r_out.result;
  assign Zero     = r_out.zero;
  assign Negative = r_out.negative;
  assign Carry    = r_out.carry;
  assign Overflow = r_out.overflow;
  assign Illegal  = r_out.illegal;
  assign out_rd   = r_out.rd;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: self-checking bench for alu_exec_stage.
// Directed vector table, hand-written backpressure / reset / throughput sequences, and a
// randomized phase scored against a queue-based reference model.
module tb_alu_exec_stage;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  ALUControl;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;
  logic        Negative;
  logic        Carry;
  logic        Overflow;
  logic        Illegal;
  logic [4:0]  out_rd;
  logic [31:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(32), .TAGW(5)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ALUControl(ALUControl),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Negative  (Negative),
    .Carry     (Carry),
    .Overflow  (Overflow),
    .Illegal   (Illegal),
    .out_rd    (out_rd),
    .op_count  (op_count)
  );

  typedef struct {
    logic [31:0] res;
    logic        z, n, c, v, ill;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] res;
    logic        z, n, c, v, ill;
  } vec_t;

  // Reference model: flags from plain wide arithmetic on the operand values.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
    exp_t            e;
    longint          sa, sb, s;
    longint unsigned ua, ub, us;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.res = '0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.rd = rd;
    case (op)
      3'd0: begin
        us = ua + ub;
        e.res = us[31:0];
        e.c = (us > 64'hFFFF_FFFF);
        s = sa + sb;
        e.v = (s > SMAX) || (s < SMIN);
      end
      3'd1: begin
        us = ua - ub;
        e.res = us[31:0];
        e.c = (ua >= ub);
        s = sa - sb;
        e.v = (s > SMAX) || (s < SMIN);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    e.n = e.res[31];
    return e;
  endfunction

  function automatic logic [63:0] pack_exp(input exp_t e);
    return {22'b0, e.res, e.z, e.n, e.c, e.v, e.ill, e.rd};
  endfunction

  function automatic logic [63:0] dut_out();
    return {22'b0, Result, Zero, Negative, Carry, Overflow, Illegal, out_rd};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    in_rd      = rd;
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_op_count", op_count, 0);
    check("reset_outputs", dut_out(), 0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  vec_t        vecs[12];
  exp_t        exp_a, exp_b, exp_c, exp_d;
  exp_t        tp_exp[8];
  exp_t        q[$];
  int          cnt;
  logic        hold;
  logic        in_f, out_f;

  initial begin
    SrcA = '0; SrcB = '0; ALUControl = '0; in_rd = '0;

    vecs[0]  = '{3'b000, 32'd5,        32'd3,        32'd8,        0, 0, 0, 0, 0};
    vecs[1]  = '{3'b001, 32'd5,        32'd5,        32'd0,        1, 0, 1, 0, 0};
    vecs[2]  = '{3'b001, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 1, 0, 0, 0};
    vecs[3]  = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'd1,        0, 0, 0, 0, 0};
    vecs[4]  = '{3'b000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 1, 0, 1, 0};
    vecs[5]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1, 0, 0, 0};
    vecs[6]  = '{3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 1, 0, 0, 0};
    vecs[7]  = '{3'b111, 32'd9,        32'd4,        32'd0,        1, 0, 0, 0, 1};
    vecs[8]  = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1, 0, 0, 0, 1};
    vecs[9]  = '{3'b110, 32'd1,        32'd2,        32'd0,        1, 0, 0, 0, 1};
    vecs[10] = '{3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 0, 1, 0, 0};
    vecs[11] = '{3'b001, 32'h80000000, 32'd1,        32'h7FFFFFFF, 0, 0, 1, 1, 0};

    do_reset();

    // Directed vectors, one isolated op each: 1-cycle latency, then drained.
    for (int i = 0; i < 12; i++) begin
      out_ready = 1'b1;
      drive_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i));
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_out", i), dut_out(),
            {22'b0, vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v, vecs[i].ill,
             5'(i)});
      @(negedge clk);
      check($sformatf("vec%0d_drain", i), out_valid, 0);
    end
    check("vec_op_count", op_count, 12);

    // Backpressure: A and B fill the buffer, C is held off until space frees up.
    do_reset();
    exp_a = model(3'b000, 32'd10, 32'd20, 5'd1);
    exp_b = model(3'b001, 32'd1, 32'd2, 5'd2);
    exp_c = model(3'b011, 32'hF0, 32'h0F, 5'd3);
    out_ready = 1'b0;
    drive_op(3'b000, 32'd10, 32'd20, 5'd1);
    @(negedge clk);
    drive_op(3'b001, 32'd1, 32'd2, 5'd2);
    check("bp_ready_one", in_ready, 1);
    check("bp_out_a", dut_out(), pack_exp(exp_a));
    @(negedge clk);
    drive_op(3'b011, 32'hF0, 32'h0F, 5'd3);
    for (int k = 0; k < 3; k++) begin
      check("bp_ready_full", in_ready, 0);
      check("bp_hold_a", dut_out(), pack_exp(exp_a));
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("bp_still_a", dut_out(), pack_exp(exp_a));
    @(negedge clk);
    check("bp_out_b", dut_out(), pack_exp(exp_b));
    check("bp_ready_after_b", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out_c", dut_out(), pack_exp(exp_c));
    check("bp_valid_c", out_valid, 1);
    @(negedge clk);
    check("bp_drained", out_valid, 0);
    check("bp_op_count", op_count, 3);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    drive_op(3'b000, 32'd1, 32'd1, 5'd4);
    @(negedge clk);
    drive_op(3'b000, 32'd2, 32'd2, 5'd5);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_full_ready", in_ready, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_ready", in_ready, 1);
    check("rst_async_count", op_count, 0);
    check("rst_async_outputs", dut_out(), 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_no_stale", out_valid, 0);
    exp_d = model(3'b010, 32'h1234, 32'hFF, 5'd9);
    drive_op(3'b010, 32'h1234, 32'hFF, 5'd9);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_first_op", dut_out(), pack_exp(exp_d));
    @(negedge clk);

    // Throughput: 8 back-to-back ops, one result per cycle.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        logic [2:0]  op;
        logic [31:0] a, b;
        op = 3'($urandom_range(0, 5));
        a  = $urandom;
        b  = $urandom;
        tp_exp[i] = model(op, a, b, 5'(i + 16));
        drive_op(op, a, b, 5'(i + 16));
        check($sformatf("tp_ready%0d", i), in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      if (i > 0) begin
        check($sformatf("tp_valid%0d", i - 1), out_valid, 1);
        check($sformatf("tp_out%0d", i - 1), dut_out(), pack_exp(tp_exp[i - 1]));
      end
      @(negedge clk);
    end
    check("tp_drained", out_valid, 0);
    check("tp_op_count", op_count, 8);

    // Randomized traffic against the queue model.
    do_reset();
    cnt  = 0;
    hold = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check("rnd_valid", out_valid, (q.size() != 0));
      check("rnd_ready", in_ready, (q.size() < 2));
      if (q.size() != 0) check("rnd_out", dut_out(), pack_exp(q[0]));
      if (!hold) begin
        logic [31:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        drive_op(3'($urandom_range(0, 7)), a, b, 5'($urandom));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      in_f  = in_valid && (q.size() < 2);
      out_f = (q.size() != 0) && out_ready;
      hold  = in_valid && !in_f;
      if (out_f) begin
        void'(q.pop_front());
        cnt++;
      end
      if (in_f) q.push_back(model(ALUControl, SrcA, SrcB, in_rd));
      @(negedge clk);
    end
    check("rnd_op_count", op_count, 64'(cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
